// File: rtl/decoder_scan_pkg.sv
// Shared types and constants for the 2x4 decoder scan controller.
package decoder_scan_pkg;

  localparam int N_SLOTS = 4;
  localparam int SEL_W   = 2;
  localparam int TMR_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Returns {found, index} of the lowest slot >= from whose mask bit is clear.
  function automatic logic [SEL_W:0] first_open(input logic [N_SLOTS-1:0] mask,
                                                input logic [SEL_W:0]   from);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if ((i >= int'(from)) && !mask[i]) r = {1'b1, SEL_W'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_scan_ctrl_slot_timer.sv
// Slot timer: 8-bit down-counter, loaded on strobe, flags terminal count at zero.
module slot_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer driving select/enable of a 2x4 decoder, with blanking gaps.
// Optional SCAN_SKIP_EN adds skip_mask[3:0] to skip slots in zero cycles.
module decoder_scan_ctrl
  import decoder_scan_pkg::*;
#(
  parameter int DIV = 4,
  parameter int GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       stop,
`ifdef SCAN_SKIP_EN
  input  logic [3:0] skip_mask,
`endif
  output logic [1:0] a,
  output logic       en,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  localparam logic [TMR_W-1:0] DIV_LD = TMR_W'(DIV - 1);
  localparam logic [TMR_W-1:0] GAP_LD = TMR_W'((GAP > 0) ? (GAP - 1) : 0);

  state_t             state, state_n;
  logic [SEL_W-1:0]   a_n;
  logic               en_n, busy_n, done_n;
  logic               stop_lat, stop_lat_n;
  logic               mode_lat, mode_lat_n;
  logic               tmr_load, tmr_tc;
  logic [TMR_W-1:0]   tmr_val;
  logic               slot_end;
  logic [SEL_W:0]     nxt_slot, wrap_slot;
  logic [N_SLOTS-1:0] mask;

`ifdef SCAN_SKIP_EN
  assign mask = skip_mask;
`else
  assign mask = '0;
`endif

  slot_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a        <= '0;
      en       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      stop_lat <= 1'b0;
      mode_lat <= 1'b0;
    end else begin
      state    <= state_n;
      a        <= a_n;
      en       <= en_n;
      busy     <= busy_n;
      done     <= done_n;
      stop_lat <= stop_lat_n;
      mode_lat <= mode_lat_n;
    end
  end

  always_comb begin
    state_n    = state;
    a_n        = a;
    en_n       = en;
    busy_n     = busy;
    done_n     = 1'b0;
    stop_lat_n = stop_lat;
    mode_lat_n = mode_lat;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    slot_end   = 1'b0;
    nxt_slot   = first_open(mask, {1'b0, a} + 3'd1);
    wrap_slot  = first_open(mask, 3'd0);

    case (state)
      IDLE: begin
        a_n    = '0;
        en_n   = 1'b0;
        busy_n = 1'b0;
        if (start && !stop) begin
          mode_lat_n = mode;
          stop_lat_n = 1'b0;
          if (wrap_slot[SEL_W]) begin
            state_n  = DRIVE;
            a_n      = wrap_slot[SEL_W-1:0];
            en_n     = 1'b1;
            busy_n   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = DIV_LD;
          end else begin
            // Every slot masked: the sweep is complete without driving anything.
            done_n = !mode;
          end
        end
      end
      DRIVE: begin
        if (stop) stop_lat_n = 1'b1;
        if (tmr_tc) begin
          if (GAP > 0) begin
            state_n  = decoder_scan_pkg::GAP;
            en_n     = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
          end else begin
            slot_end = 1'b1;
          end
        end
      end
      decoder_scan_pkg::GAP: begin
        if (stop) stop_lat_n = 1'b1;
        if (tmr_tc) slot_end = 1'b1;
      end
      default: begin
        state_n = IDLE;
        a_n     = '0;
        en_n    = 1'b0;
        busy_n  = 1'b0;
      end
    endcase

    // A stop seen in the slot's final cycle still counts for this slot.
    if (slot_end) begin
      if (stop || stop_lat) begin
        state_n    = IDLE;
        a_n        = '0;
        en_n       = 1'b0;
        busy_n     = 1'b0;
        stop_lat_n = 1'b0;
      end else if (nxt_slot[SEL_W] || (mode_lat && wrap_slot[SEL_W])) begin
        state_n  = DRIVE;
        a_n      = nxt_slot[SEL_W] ? nxt_slot[SEL_W-1:0] : wrap_slot[SEL_W-1:0];
        en_n     = 1'b1;
        busy_n   = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = DIV_LD;
      end else begin
        state_n = IDLE;
        a_n     = '0;
        en_n    = 1'b0;
        busy_n  = 1'b0;
        done_n  = !mode_lat;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: expected per-cycle {busy,done,en,a} queued at stimulus time.
module tb_decoder_scan_ctrl;

  localparam int DIV  = 4;
  localparam int GAP  = 1;
  localparam int DIV0 = 2;

  logic       clk = 1'b0;
  logic       rst, start, mode, stop;
  logic [1:0] a, a0, st, st0;
  logic       en, busy, done, en0, busy0, done0;
`ifdef SCAN_SKIP_EN
  logic [3:0] skip_mask;
`endif

  logic [4:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.DIV(DIV), .GAP(GAP)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .stop(stop),
`ifdef SCAN_SKIP_EN
    .skip_mask(skip_mask),
`endif
    .a(a), .en(en), .busy(busy), .done(done), .dbg_state(st)
  );

  decoder_scan_ctrl #(.DIV(DIV0), .GAP(0)) u_dut_g0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .stop(stop),
`ifdef SCAN_SKIP_EN
    .skip_mask(skip_mask),
`endif
    .a(a0), .en(en0), .busy(busy0), .done(done0), .dbg_state(st0)
  );

  task automatic push_slot(input int div, input int gap, input logic [1:0] idx);
    for (int i = 0; i < div; i++) exp_q.push_back({1'b1, 1'b0, 1'b1, idx});
    for (int i = 0; i < gap; i++) exp_q.push_back({1'b1, 1'b0, 1'b0, idx});
  endtask

  task automatic push_idle(input logic d);
    exp_q.push_back({1'b0, d, 1'b0, 2'b00});
  endtask

  task automatic push_sweep(input int div, input int gap);
    for (int s = 0; s < 4; s++) push_slot(div, gap, 2'(s));
    push_idle(1'b1);
    push_idle(1'b0);
  endtask

  // Compare the current cycle against the queue head, then advance one cycle.
  task automatic check_one(input string name, input bit g0);
    logic [4:0] obs, exp;
    obs = g0 ? {busy0, done0, en0, a0} : {busy, done, en, a};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: no expected entry, got busy/done/en/a=%b", name, obs);
    end else begin
      exp = exp_q.pop_front();
      if (obs !== exp) begin
        bad++;
        $display("FAIL %s @%0t: busy/done/en/a got=%b exp=%b", name, $time, obs, exp);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name, input bit g0);
    while (exp_q.size() > 0) check_one(name, g0);
  endtask

  task automatic pulse_start(input logic m);
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mode = 1'b0; stop = 1'b0;
`ifdef SCAN_SKIP_EN
    skip_mask = 4'b0000;
`endif
    @(posedge clk); #1;
    push_idle(1'b0);
    push_idle(1'b0);
    check_one("reset_hold", 1'b0);
    check_one("reset_hold", 1'b0);
    rst = 1'b0; start = 1'b0;
    push_idle(1'b0);
    drain("reset_release", 1'b0);
  endtask

  task automatic test_single_sweep();
    pulse_start(1'b0);
    push_sweep(DIV, GAP);
    drain("single_sweep", 1'b0);
  endtask

  // Mode is dropped right after start to show the latched copy governs the wrap.
  task automatic test_continuous_stop();
    pulse_start(1'b1);
    mode = 1'b0;
    for (int s = 0; s < 4; s++) push_slot(DIV, GAP, 2'(s));
    push_slot(DIV, GAP, 2'd0);
    push_slot(DIV, GAP, 2'd1);
    push_idle(1'b0);
    push_idle(1'b0);
    for (int i = 0; i < 27; i++) check_one("continuous", 1'b0);
    stop = 1'b1;
    check_one("continuous_stop", 1'b0);
    stop = 1'b0;
    drain("continuous_stop", 1'b0);
  endtask

  task automatic test_back_to_back();
    pulse_start(1'b0);
    push_sweep(DIV, GAP);
    for (int i = 0; i < 6; i++) check_one("start_while_busy", 1'b0);
    start = 1'b1;
    mode  = 1'b1;
    check_one("start_while_busy", 1'b0);
    start = 1'b0;
    mode  = 1'b0;
    drain("start_while_busy", 1'b0);
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 3; i++) push_idle(1'b0);
    drain("start_and_stop", 1'b0);
  endtask

  task automatic test_reset_mid();
    pulse_start(1'b0);
    push_sweep(DIV, GAP);
    for (int i = 0; i < 13; i++) check_one("reset_mid_pre", 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    push_idle(1'b0);
    check_one("reset_mid", 1'b0);
    pulse_start(1'b0);
    push_sweep(DIV, GAP);
    drain("restart_after_reset", 1'b0);
  endtask

  // Zero-gap instance: en stays high across slots while a steps.
  task automatic test_gap0();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pulse_start(1'b0);
    push_sweep(DIV0, 0);
    drain("gap0_sweep", 1'b1);
  endtask

`ifdef SCAN_SKIP_EN
  task automatic test_skip();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    skip_mask = 4'b0101;
    pulse_start(1'b0);
    push_slot(DIV, GAP, 2'd1);
    push_slot(DIV, GAP, 2'd3);
    push_idle(1'b1);
    push_idle(1'b0);
    drain("skip_0101", 1'b0);
    skip_mask = 4'b1111;
    pulse_start(1'b0);
    push_idle(1'b1);
    push_idle(1'b0);
    drain("skip_all_single", 1'b0);
    pulse_start(1'b1);
    push_idle(1'b0);
    push_idle(1'b0);
    drain("skip_all_cont", 1'b0);
    skip_mask = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_single_sweep();
    test_continuous_stop();
    test_back_to_back();
    test_start_stop_idle();
    test_reset_mid();
    test_gap0();
`ifdef SCAN_SKIP_EN
    test_skip();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
